exp_smoothing_mc: RTL and testbench

//  Time-multiplexed multi-channel exponential smoothing: val[c] += (in - val[c]) >> beta_shift.

---
 rtl/exp_smoothing_mc.sv | 83 ++++++++
 tb/tb_exp_smoothing_mc.sv | 135 +++++++++++++
 2 files changed

// File: rtl/exp_smoothing_mc.sv
// exp_smoothing_mc: round-robin multi-channel exponential smoothing, val[c] += (in - val[c]) >> beta_shift
// Define EXP_SMOOTH_SAT_EN to saturate on overflow instead of wrapping.
module exp_smoothing_mc #(
  parameter int NCH       = 15,
  parameter int IN_WH     = 32,
  parameter int IN_FR     = 30,
  parameter int VAL_WH    = 32,
  parameter int VAL_FR    = 30,
  parameter int BSW       = 4,
  parameter int MAX_SHIFT = 12,
  localparam int CW       = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clr,
  input  logic [BSW-1:0]    beta_shift,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_WH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VAL_WH-1:0] out_data,
  output logic [CW-1:0]     out_ch
);
  localparam int SH = IN_FR - VAL_FR;
  localparam int AW = IN_WH - SH;
  localparam int XW = AW + 2;
  typedef enum logic {WARM, RUN} state_t;
  state_t state, state_nx;
  logic signed [VAL_WH-1:0] val [NCH];
  logic [CW-1:0] ch_cnt;
  logic accept;
  logic [BSW-1:0] b;
  logic signed [XW-1:0] ain, cur, d, t, r, sum, nx_wide;
  logic [VAL_WH-1:0] nx;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign b = beta_shift > BSW'(MAX_SHIFT) ? BSW'(MAX_SHIFT) : beta_shift;
  // all arithmetic carries two guard bits so diff, rounding and the add are exact
  assign ain = XW'($signed(in_data[IN_WH-1:SH]));
  assign cur = XW'(val[ch_cnt]);
  assign d = ain - cur;
  assign t = d >>> (b - BSW'(1));
  assign r = (t + XW'(1)) >>> 1;
  assign sum = cur + r;
  assign nx_wide = (state == WARM || b == '0) ? ain : sum;
`ifdef EXP_SMOOTH_SAT_EN
  logic ovf;
  assign ovf = nx_wide[XW-1:VAL_WH-1] != {(XW-VAL_WH+1){nx_wide[XW-1]}};
  assign nx = ovf ? {nx_wide[XW-1], {(VAL_WH-1){~nx_wide[XW-1]}}} : nx_wide[VAL_WH-1:0];
`else
  logic unused_hi;
  assign unused_hi = ^nx_wide[XW-1:VAL_WH];
  assign nx = nx_wide[VAL_WH-1:0];
`endif
  always_comb begin
    state_nx = state;
    if (clr) state_nx = WARM;
    else if (state == WARM && accept && ch_cnt == CW'(NCH-1)) state_nx = RUN;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= WARM;
      ch_cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      for (int i = 0; i < NCH; i++) val[i] <= '0;
    end else begin
      state <= state_nx;
      out_valid <= (accept && !clr) ? 1'b1 : out_ready ? 1'b0 : out_valid;
      if (clr) begin
        ch_cnt <= '0;
        for (int i = 0; i < NCH; i++) val[i] <= '0;
      end else if (accept) begin
        val[ch_cnt] <= nx;
        ch_cnt <= ch_cnt == CW'(NCH-1) ? '0 : ch_cnt + 1'b1;
        out_data <= nx;
        out_ch <= ch_cnt;
      end
    end
  end
endmodule

// File: tb/tb_exp_smoothing_mc.sv
// tb_exp_smoothing_mc: scoreboard bench for exp_smoothing_mc plus a wide-input instance for the overflow rule
module tb_exp_smoothing_mc;
  logic clk = 0, nrst = 0, clr = 0;
  logic [3:0] beta_shift = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [31:0] in_data = 0, out_data;
  logic [3:0] out_ch;
  logic [3:0] v_beta = 0;
  logic v_valid = 0, v_ready, v_out_valid;
  logic [33:0] v_data = 0;
  logic [31:0] v_out_data;
  logic [3:0] v_out_ch;
  logic [35:0] exp_q[$];
  int checks = 0, errors = 0;
  logic [3:0] exp_ch = 0;

  always #5 clk = ~clk;

  exp_smoothing_mc dut (
    .clk(clk), .nrst(nrst), .clr(clr), .beta_shift(beta_shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
  );

  exp_smoothing_mc #(.IN_WH(34)) u34 (
    .clk(clk), .nrst(nrst), .clr(1'b0), .beta_shift(v_beta),
    .in_valid(v_valid), .in_ready(v_ready), .in_data(v_data),
    .out_valid(v_out_valid), .out_ready(1'b1), .out_data(v_out_data), .out_ch(v_out_ch)
  );

`ifdef EXP_SMOOTH_SAT_EN
  localparam logic [31:0] E34_B0 = 32'h7FFFFFFF, E34_B1 = 32'h7FFFFFFF;
`else
  localparam logic [31:0] E34_B0 = 32'h00000000, E34_B1 = 32'h80000000;
`endif

  always @(negedge clk) begin
    logic [35:0] e;
    if (nrst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected got ch %0d data %h with no expected entry", out_ch, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_ch, out_data} !== e) begin
          errors++;
          $display("FAIL out got ch %0d data %h want ch %0d data %h", out_ch, out_data, e[35:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] bs, input logic [31:0] e);
    int k;
    in_valid = 1; in_data = d; beta_shift = bs;
    for (k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout in_ready %b want 1", in_ready);
    end
    exp_q.push_back({exp_ch, e});
    exp_ch = exp_ch == 14 ? 4'd0 : exp_ch + 4'd1;
    @(posedge clk); #1;
  endtask

  initial begin
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ch", 64'(out_ch), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); nrst = 1;
    @(posedge clk); #1;
    // warm start: each channel seeded with its first sample
    for (int i = 0; i < 15; i++) send(32'h10000000, 4'd4, 32'h10000000);
    send(32'h40000000, 4'd4, 32'h13000000);
    send(32'h10000000, 4'd15, 32'h10000000);
    send(32'h00000000, 4'd0, 32'h00000000);
    send(32'h20000000, 4'd1, 32'h18000000);
    out_ready = 0; in_valid = 1; in_data = 32'h20000000; beta_shift = 4'd1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold", {28'd0, out_ch, out_data}, {28'd0, 4'd3, 32'h18000000});
    end
    out_ready = 1;
    send(32'h20000000, 4'd1, 32'h18000000);
    send(32'h20000000, 4'd1, 32'h18000000);
    send(32'h20000000, 4'd1, 32'h18000000);
    // clr on ch 7 with a live sample: the sample is discarded
    clr = 1; in_valid = 1; in_data = 32'h77777777;
    @(posedge clk); #1;
    clr = 0; exp_ch = 0;
    for (int i = 0; i < 15; i++) send(32'h00000000, 4'd3, 32'h00000000);
    send(32'h40000000, 4'd4, 32'h04000000);
    send(32'h00000001, 4'd1, 32'h00000001);
    send(32'hFFFFFFFF, 4'd1, 32'h00000000);
    send(32'hC0000000, 4'd2, 32'hF0000000);
    for (int i = 4; i < 15; i++) send(32'h00000000, 4'd4, 32'h00000000);
    send(32'h40000000, 4'd4, 32'h07C00000);
    send(32'h00000001 - 32'h40000001 - 32'h0, 4'd2, 32'hF0000001);
    // async reset mid-stream clears outputs without waiting for a clock
    in_valid = 0; #1; nrst = 0; #1;
    chk("nrst_out_valid", 64'(out_valid), 64'd0);
    chk("nrst_out_data", 64'(out_data), 64'd0);
    chk("nrst_out_ch", 64'(out_ch), 64'd0);
    exp_q.delete(); exp_ch = 0;
    @(negedge clk); nrst = 1;
    @(posedge clk); #1;
    send(32'h12345678, 4'd0, 32'h12345678);
    in_valid = 0;
    repeat (3) @(negedge clk);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    // 34-bit input holding 4.0 overflows the 32-bit state
    for (int i = 0; i < 17; i++) begin
      v_valid = 1; v_data = 34'h100000000; v_beta = (i == 16) ? 4'd1 : 4'd0;
      @(posedge clk); #1;
      chk("w34_valid_ch", {59'd0, v_out_valid, v_out_ch}, {59'd1, 4'(i % 15)});
      chk("w34_data", 64'(v_out_data), 64'(i == 16 ? E34_B1 : E34_B0));
    end
    v_valid = 0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
